// File: rtl/seq_pkg.sv
// Shared types for the fetch sequencer: instruction classes, FSM states and
// the decoded-instruction bundle handed from seq_decode to the control FSM.
package seq_pkg;

  typedef enum logic [1:0] {
    OP_ALU = 2'b00,
    OP_JMP = 2'b01,
    OP_BZ  = 2'b10,
    OP_SYS = 2'b11
  } opcls_e;

  localparam logic [5:0] SYS_HALT = 6'h3F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STALL,
    S_HALT
  } state_e;

  typedef struct packed {
    opcls_e     cls;
    logic [5:0] target;
    logic [1:0] alu_op;
    logic [3:0] alu_operand;
  } dec_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and ALU-datapath signals seen by the fetch sequencer.
// master = sequencer side, slave = memory/datapath side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        instruction;
  logic              branch;
  logic [ADDR_W-1:0] branchaddress;
  logic              alu_valid;
  logic [1:0]        alu_op;
  logic [3:0]        alu_operand;
  logic              alu_ready;
  logic              zero_flag;

  modport master (
    input  instruction, alu_ready, zero_flag,
    output branch, branchaddress, alu_valid, alu_op, alu_operand
  );

  modport slave (
    output instruction, alu_ready, zero_flag,
    input  branch, branchaddress, alu_valid, alu_op, alu_operand
  );
endinterface

// File: rtl/seq_decode.sv
// Pure field split of an instruction word; no state, no policy.
module seq_decode
  import seq_pkg::*;
(
  input  logic [7:0] instruction,
  output dec_t       dec
);
  assign dec.cls         = opcls_e'(instruction[7:6]);
  assign dec.target      = instruction[5:0];
  assign dec.alu_op      = instruction[5:4];
  assign dec.alu_operand = instruction[3:0];
endmodule

// File: rtl/fetch_sequencer.sv
// Control FSM for the 8-bit core: steers the instruction memory PC, issues ALU
// ops over valid/ready, and keeps a PC mirror plus a saturating retire count.
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   bus,
  input  logic                run,
  output logic                halted,
  output logic [ADDR_W-1:0]   pc,
  output logic [CNT_W-1:0]    retired
);

  state_e            state, nxt;
  dec_t              dec;
  logic              hazard;
  logic              br, vld, retire, xfer;
  logic [ADDR_W-1:0] baddr, tgt;

  seq_decode u_dec (
    .instruction (bus.instruction),
    .dec         (dec)
  );

  assign tgt = ADDR_W'(dec.target);

  // Holding the PC is done by re-branching to the current address.
  always_comb begin
    nxt    = state;
    br     = 1'b0;
    baddr  = pc;
    vld    = 1'b0;
    retire = 1'b0;
    case (state)
      S_IDLE: begin
        br = 1'b1;
        if (run) nxt = S_RUN;
      end
      S_RUN, S_STALL: begin
        nxt = S_RUN;
        case (dec.cls)
          OP_ALU: begin
            vld = 1'b1;
            if (bus.alu_ready) retire = 1'b1;
            else begin
              br  = 1'b1;
              nxt = S_STALL;
            end
          end
          OP_JMP: begin
            br     = 1'b1;
            baddr  = tgt;
            retire = 1'b1;
          end
          OP_BZ: begin
            // zero_flag is stale the cycle right after a transfer: wait one.
            if (hazard) begin
              br  = 1'b1;
              nxt = S_STALL;
            end else begin
              retire = 1'b1;
              if (bus.zero_flag) begin
                br    = 1'b1;
                baddr = tgt;
              end
            end
          end
          OP_SYS: begin
            retire = 1'b1;
            if (dec.target == SYS_HALT) begin
              br  = 1'b1;
              nxt = S_HALT;
            end
          end
          default: ;
        endcase
      end
      S_HALT: begin
        if (run) nxt = S_RUN;
        else     br  = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign xfer = vld & bus.alu_ready;

  // Outputs forced quiet while reset is held; internal next-state is unaffected.
  assign bus.branch        = br & rst;
  assign bus.branchaddress = rst ? baddr : '0;
  assign bus.alu_valid     = vld & rst;
  assign bus.alu_op        = dec.alu_op;
  assign bus.alu_operand   = dec.alu_operand;
  assign halted            = (state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      hazard  <= 1'b0;
      retired <= '0;
    end else begin
      state  <= nxt;
      pc     <= br ? baddr : pc + 1'b1;
      hazard <= xfer;
      if (retire && retired != '1) retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural memory + accumulator datapath, an
// ISA-level reference model feeding an ALU-transfer scoreboard, and cycle checks.
module tb_fetch_sequencer;
  localparam int AW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          halted;
  logic [AW-1:0] pc;
  logic [CW-1:0] retired;

  fetch_sequencer_if #(.ADDR_W(AW)) bus ();

  fetch_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .run     (run),
    .halted  (halted),
    .pc      (pc),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(string nm, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Behavioural instruction memory and 4-bit accumulator datapath
  logic [7:0]    mem [64];
  logic [AW-1:0] mpc;
  logic [3:0]    acc;
  logic          s_br, s_x;
  logic [AW-1:0] s_ba;
  logic [5:0]    s_w;
  bit            force_en = 1'b0;
  bit            force_v  = 1'b0;
  int            nr = 0;
  logic [5:0]    exp_q[$];

  assign bus.instruction = mem[mpc];
  assign bus.zero_flag   = (acc == 4'd0);

  function automatic logic [3:0] alu_f(logic [3:0] a, logic [1:0] op, logic [3:0] d);
    case (op)
      2'd0:    return d;
      2'd1:    return a + d;
      2'd2:    return a - d;
      default: return a ^ d;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mpc <= '0;
      acc <= '0;
    end else begin
      mpc <= s_br ? s_ba : mpc + 6'd1;
      if (s_x) acc <= alu_f(acc, s_w[5:4], s_w[3:0]);
    end
  end

  always @(posedge clk) begin
    #1;
    bus.alu_ready = force_en ? force_v : ($urandom_range(99) < 70);
  end

  // Monitor: samples mid-cycle, checks the PC mirror and scores ALU transfers
  always @(negedge clk) begin
    s_br = bus.branch;
    s_ba = bus.branchaddress;
    s_x  = bus.alu_valid & bus.alu_ready;
    s_w  = {bus.alu_op, bus.alu_operand};
    if (rst) begin
      chk("pc_mirror", int'(pc), int'(mpc));
      if (bus.alu_valid && !bus.alu_ready) nr++;
      if (s_x) begin
        if (exp_q.size() == 0) chk("alu_xfer_unexpected", int'(s_w), -1);
        else chk("alu_xfer", int'(s_w), int'(exp_q.pop_front()));
      end
    end
  end

  // ISA-level reference: executes the program word by word
  int         e_ret, e_hz, e_pc;
  bit         e_ok;

  task automatic model();
    int         p = 0;
    logic [3:0] a = 4'd0;
    bit         prev_alu = 1'b0;
    logic [7:0] w;
    e_ret = 0; e_hz = 0; e_pc = 0; e_ok = 1'b0;
    exp_q.delete();
    for (int s = 0; s < 300; s++) begin
      w = mem[p];
      e_ret++;
      case (w[7:6])
        2'b00: begin
          exp_q.push_back(w[5:0]);
          a = alu_f(a, w[5:4], w[3:0]);
          p = (p + 1) % 64;
        end
        2'b01: p = int'(w[5:0]);
        2'b10: begin
          if (prev_alu) e_hz++;
          p = (a == 4'd0) ? int'(w[5:0]) : (p + 1) % 64;
        end
        default: begin
          if (w[5:0] == 6'h3F) begin
            e_pc = p;
            e_ok = 1'b1;
            return;
          end
          p = (p + 1) % 64;
        end
      endcase
      prev_alu = (w[7:6] == 2'b00);
    end
  endtask

  function automatic logic [7:0] rand_word();
    int         r = $urandom_range(99);
    logic [5:0] t = 6'($urandom_range(63));
    if (r < 45) return {2'b00, t};
    if (r < 60) return {2'b01, t};
    if (r < 78) return {2'b10, t};
    if (r < 88) return {2'b11, (t == 6'h3F) ? 6'h00 : t};
    return 8'hFF;
  endfunction

  int cyc;
  int pcs[$];

  function automatic int pcat(int i);
    return (i < pcs.size()) ? pcs[i] : -1;
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
  endtask

  task automatic start_prog();
    @(posedge clk); #2;
    rst = 1'b0;
    model();
    nr = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    run = 1'b1;
    cyc = 0;
    pcs.delete();
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == 1) run = 1'b0;
    pcs.push_back(int'(pc));
  endtask

  task automatic finish_prog(string nm);
    while (!halted && cyc < 3000) step();
    chk({nm, "_halted"},  int'(halted), 1);
    chk({nm, "_retired"}, int'(retired), e_ret);
    chk({nm, "_pc"},      int'(pc), e_pc);
    chk({nm, "_cycles"},  cyc, 1 + e_ret + e_hz + nr);
    chk({nm, "_queue"},   exp_q.size(), 0);
    step();
    chk({nm, "_hold"},    int'(pc), e_pc);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    #1 rst = 1'b0;
    #1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_branch", int'(bus.branch), 0);
    chk("rst_baddr", int'(bus.branchaddress), 0);
    chk("rst_valid", int'(bus.alu_valid), 0);

    // NOP, JMP 5, HALT
    force_en = 1'b1; force_v = 1'b1;
    fill_halt(); mem[0] = 8'hC0; mem[1] = 8'h45;
    start_prog();
    finish_prog("basic");
    chk("basic_pc0", pcat(0), 0);
    chk("basic_pc1", pcat(1), 1);
    chk("basic_pc2", pcat(2), 5);
    chk("basic_pc3", pcat(3), 5);

    // ALU with three not-ready cycles
    fill_halt(); mem[0] = 8'h25;
    force_v = 1'b0;
    start_prog();
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid", int'(bus.alu_valid), 1);
      chk("stall_opword", int'({bus.alu_op, bus.alu_operand}), 'h25);
      if (k < 3) begin
        chk("stall_branch", int'(bus.branch), 1);
        chk("stall_target", int'(bus.branchaddress), 0);
      end else chk("accept_branch", int'(bus.branch), 0);
      if (k == 2) force_v = 1'b1;
      if (k < 3) step();
    end
    finish_prog("alu_stall");

    // ALU load 0 then BZ 10: one hazard cycle, then taken
    fill_halt(); mem[0] = 8'h00; mem[1] = 8'h8A;
    start_prog();
    finish_prog("bz_hazard");
    chk("bz_hazard_pc1", pcat(1), 1);
    chk("bz_hazard_pc2", pcat(2), 1);
    chk("bz_hazard_pc3", pcat(3), 10);

    // Wrap 62 -> 63 -> 0, then untaken BZ falls through to HALT
    fill_halt();
    mem[0] = 8'h82; mem[2] = 8'h01; mem[3] = 8'h7E; mem[62] = 8'hC0; mem[63] = 8'hC0;
    start_prog();
    finish_prog("wrap");
    chk("wrap_pc62", pcat(3), 62);
    chk("wrap_pc63", pcat(4), 63);
    chk("wrap_pc0",  pcat(5), 0);
    chk("wrap_bz_fall", pcat(6), 1);

    // Reset asserted while an ALU op is stalled
    fill_halt(); mem[0] = 8'h25;
    force_v = 1'b0;
    start_prog();
    step(); step();
    @(negedge clk);
    chk("rstall_pre_valid", int'(bus.alu_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("rstall_valid", int'(bus.alu_valid), 0);
    chk("rstall_branch", int'(bus.branch), 0);
    chk("rstall_baddr", int'(bus.branchaddress), 0);
    chk("rstall_pc", int'(pc), 0);
    chk("rstall_retired", int'(retired), 0);
    chk("rstall_halted", int'(halted), 0);
    run = 1'b1; force_v = 1'b1; nr = 0;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 0; pcs.delete();
    finish_prog("restart");
    chk("restart_pc0", pcat(0), 0);
    chk("restart_pc1", pcat(1), 1);

    // Random programs with random back-pressure
    force_en = 1'b0;
    for (int n = 0; n < 25; n++) begin
      e_ok = 1'b0;
      while (!e_ok) begin
        for (int i = 0; i < 64; i++) mem[i] = rand_word();
        model();
      end
      start_prog();
      finish_prog($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", npass, ntot);
    $fatal(1);
  end

endmodule
